// File: rtl/fewcore_pkg.sv
// fewcore_pkg: shared core constants and the prefetch entry type
package fewcore_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: circular buffer of PC-tagged instruction words
module prefetch_fifo
  import fewcore_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [AW:0]  count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clear && !reset) mem[wr_ptr] <= din;
  end
  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/prefetch_buffer.sv
// prefetch_buffer: sequential instruction prefetch with branch redirect and in-flight squash
module prefetch_buffer
  import fewcore_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_data,
  input  logic            originPc,
  input  logic [XLEN-1:0] pcBranch,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] pc_out
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] fetch_pc, resp_pc, target;
  logic [AW:0] count, outstanding, drop_cnt;
  logic push, pop;
  fetch_entry_t head;
  assign target     = {pcBranch[XLEN-1:2], 2'b00};
  assign imem_req   = !reset && !originPc &&
                      (({1'b0, count} + {1'b0, outstanding}) < (AW+2)'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign push       = imem_valid && (drop_cnt == '0) && !originPc;
  assign inst_valid = !reset && !originPc && (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_out   = head.inst;
  assign pc_out     = head.pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + (AW+1)'(imem_req) - (AW+1)'(imem_valid);
      fetch_pc    <= originPc ? target : imem_req ? fetch_pc + XLEN'(INST_BYTES) : fetch_pc;
      resp_pc     <= originPc ? target : push ? resp_pc + XLEN'(INST_BYTES) : resp_pc;
      drop_cnt    <= originPc ? outstanding - (AW+1)'(imem_valid)
                              : drop_cnt - (AW+1)'(imem_valid && (drop_cnt != '0));
    end
  end
  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (originPc),
    .din   ({resp_pc, imem_data}),
    .head  (head),
    .count (count)
  );
endmodule
